// File: rtl/hc_traffic_controller.sv
// hc_traffic_controller: highway/country-road junction lights, sensor-driven Moore FSM
module hc_traffic_controller #(
  parameter int Y2RDELAY = 3,
  parameter int R2GDELAY = 2,
  parameter int CNT_W    = 4
) (
  output logic [2:0] MAIN_SIG,
  output logic [2:0] CNTRY_SIG,
  input  logic       CAR_ON_CNTRY_RD,
  input  logic       CLOCK,
  input  logic       CLEAR
);
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [CNT_W-1:0] Y_LD = CNT_W'(Y2RDELAY - 1);
  localparam logic [CNT_W-1:0] R_LD = CNT_W'(R2GDELAY - 1);
  typedef enum logic [2:0] {S0, S1, S2, S3, S4} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  // sequence the lamps; outputs are registered alongside each state change
  always_ff @(posedge CLOCK or posedge CLEAR) begin
    if (CLEAR) begin
      state     <= S0;
      cnt       <= '0;
      MAIN_SIG  <= GREEN;
      CNTRY_SIG <= RED;
    end else begin
      case (state)
        S0: if (CAR_ON_CNTRY_RD) begin
          state     <= S1;
          cnt       <= Y_LD;
          MAIN_SIG  <= YELLOW;
          CNTRY_SIG <= RED;
        end
        S1: if (cnt == '0) begin
          state     <= S2;
          cnt       <= R_LD;
          MAIN_SIG  <= RED;
          CNTRY_SIG <= RED;
        end else cnt <= cnt - CNT_W'(1);
        S2: if (cnt == '0) begin
          state     <= S3;
          MAIN_SIG  <= RED;
          CNTRY_SIG <= GREEN;
        end else cnt <= cnt - CNT_W'(1);
        S3: if (!CAR_ON_CNTRY_RD) begin
          state     <= S4;
          cnt       <= Y_LD;
          MAIN_SIG  <= RED;
          CNTRY_SIG <= YELLOW;
        end
        S4: if (cnt == '0) begin
          state     <= S0;
          MAIN_SIG  <= GREEN;
          CNTRY_SIG <= RED;
        end else cnt <= cnt - CNT_W'(1);
        default: begin
          state     <= S0;
          cnt       <= '0;
          MAIN_SIG  <= GREEN;
          CNTRY_SIG <= RED;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hc_traffic_controller.sv
// tb_hc_traffic_controller: table vectors, hand sequences and random run against a phase/timeline model
module tb_hc_traffic_controller;
  logic clk = 1'b0;
  logic clear, car, car_r;
  logic [2:0] m0, c0, m1, c1;
  int errors = 0;
  int checks = 0;
  int ph[2];
  int el[2];
  int yd[2] = '{3, 5};
  int rd[2] = '{2, 1};
  int n_my[2], n_ar[2], n_cy[2], n_cg[2];
  typedef struct packed {logic car; logic [2:0] m; logic [2:0] c;} vec_t;
  vec_t tbl[22];

  hc_traffic_controller dut0 (
    .MAIN_SIG(m0), .CNTRY_SIG(c0), .CAR_ON_CNTRY_RD(car), .CLOCK(clk), .CLEAR(clear)
  );
  hc_traffic_controller #(.Y2RDELAY(5), .R2GDELAY(1)) dut1 (
    .MAIN_SIG(m1), .CNTRY_SIG(c1), .CAR_ON_CNTRY_RD(car), .CLOCK(clk), .CLEAR(clear)
  );

  always #5 clk = ~clk;

  // phases: 0 highway green, 1 highway yellow, 2 all red, 3 country green, 4 country yellow
  function automatic logic [2:0] exp_main(int p);
    return p == 0 ? 3'b001 : p == 1 ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] exp_cntry(int p);
    return p == 3 ? 3'b001 : p == 4 ? 3'b010 : 3'b100;
  endfunction

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_safe(input string name, input logic [2:0] m, input logic [2:0] c);
    checks++;
    if (m !== 3'b100 && c !== 3'b100) begin
      errors++;
      $display("FAIL %s: main %b cntry %b both not red", name, m, c);
    end
  endtask

  task automatic step(input int i, input logic c);
    case (ph[i])
      0: if (c) begin ph[i] = 1; el[i] = 0; end
      1: begin el[i]++; if (el[i] == yd[i]) begin ph[i] = 2; el[i] = 0; end end
      2: begin el[i]++; if (el[i] == rd[i]) begin ph[i] = 3; el[i] = 0; end end
      3: if (!c) begin ph[i] = 4; el[i] = 0; end
      default: begin el[i]++; if (el[i] == yd[i]) begin ph[i] = 0; el[i] = 0; end end
    endcase
  endtask

  task automatic check_all();
    chk("main0", m0, exp_main(ph[0]));
    chk("cntry0", c0, exp_cntry(ph[0]));
    chk("main1", m1, exp_main(ph[1]));
    chk("cntry1", c1, exp_cntry(ph[1]));
    chk_safe("safe0", m0, c0);
    chk_safe("safe1", m1, c1);
    if (m0 == 3'b010) n_my[0]++;
    if (m1 == 3'b010) n_my[1]++;
    if (m0 == 3'b100 && c0 == 3'b100) n_ar[0]++;
    if (m1 == 3'b100 && c1 == 3'b100) n_ar[1]++;
    if (c0 == 3'b010) n_cy[0]++;
    if (c1 == 3'b010) n_cy[1]++;
    if (c0 == 3'b001) n_cg[0]++;
    if (c1 == 3'b001) n_cg[1]++;
  endtask

  task automatic tick(input logic c);
    car = c;
    @(posedge clk);
    if (!clear) begin
      step(0, c);
      step(1, c);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 2; i++) begin
      n_my[i] = 0; n_ar[i] = 0; n_cy[i] = 0; n_cg[i] = 0;
    end
  endtask

  task automatic async_reset(input string name);
    #2 clear = 1'b1;
    #1;
    ph = '{0, 0};
    el = '{0, 0};
    chk({name, "_main0"}, m0, 3'b001);
    chk({name, "_cntry0"}, c0, 3'b100);
    chk({name, "_main1"}, m1, 3'b001);
    chk({name, "_cntry1"}, c1, 3'b100);
    @(negedge clk);
    tick(1'b0);
    tick(1'b1);
    clear = 1'b0;
    for (int k = 0; k < 5; k++) tick(1'b0);
    chk({name, "_idle_main0"}, m0, 3'b001);
  endtask

  initial begin
    tbl = '{
      '{1'b1, 3'b010, 3'b100}, '{1'b0, 3'b010, 3'b100}, '{1'b1, 3'b010, 3'b100},
      '{1'b0, 3'b100, 3'b100}, '{1'b1, 3'b100, 3'b100}, '{1'b1, 3'b100, 3'b001},
      '{1'b1, 3'b100, 3'b001}, '{1'b0, 3'b100, 3'b010}, '{1'b1, 3'b100, 3'b010},
      '{1'b1, 3'b100, 3'b010}, '{1'b1, 3'b001, 3'b100}, '{1'b1, 3'b010, 3'b100},
      '{1'b0, 3'b010, 3'b100}, '{1'b0, 3'b010, 3'b100}, '{1'b0, 3'b100, 3'b100},
      '{1'b0, 3'b100, 3'b100}, '{1'b0, 3'b100, 3'b001}, '{1'b0, 3'b100, 3'b010},
      '{1'b0, 3'b100, 3'b010}, '{1'b0, 3'b100, 3'b010}, '{1'b0, 3'b001, 3'b100},
      '{1'b0, 3'b001, 3'b100}
    };
    ph = '{0, 0};
    el = '{0, 0};
    clr_counts();
    clear = 1'b1;
    car = 1'b0;
    for (int k = 0; k < 5; k++) tick(1'b0);
    clear = 1'b0;
    for (int k = 0; k < 15; k++) tick(1'b0);
    for (int k = 0; k < 22; k++) begin
      tick(tbl[k].car);
      chk($sformatf("tbl%0d_main", k), m0, tbl[k].m);
      chk($sformatf("tbl%0d_cntry", k), c0, tbl[k].c);
    end
    for (int k = 0; k < 20; k++) tick(1'b0);
    for (int b = 0; b < 3; b++) begin
      clr_counts();
      for (int k = 0; k < 20; k++) tick(1'b0);
      for (int k = 0; k < 10; k++) tick(1'b1);
      for (int k = 0; k < 20; k++) tick(1'b0);
      chk_int($sformatf("burst%0d_myel0", b), n_my[0], 3);
      chk_int($sformatf("burst%0d_allred0", b), n_ar[0], 2);
      chk_int($sformatf("burst%0d_cgreen0", b), n_cg[0], 5);
      chk_int($sformatf("burst%0d_cyel0", b), n_cy[0], 3);
      chk_int($sformatf("burst%0d_myel1", b), n_my[1], 5);
      chk_int($sformatf("burst%0d_allred1", b), n_ar[1], 1);
      chk_int($sformatf("burst%0d_cgreen1", b), n_cg[1], 4);
      chk_int($sformatf("burst%0d_cyel1", b), n_cy[1], 5);
    end
    tick(1'b1);
    for (int k = 0; k < 3; k++) tick(1'b0);
    chk("pre_rst_s2_main0", m0, 3'b100);
    async_reset("rst_s2");
    for (int k = 0; k < 8; k++) tick(1'b1);
    chk("pre_rst_s3_cntry0", c0, 3'b001);
    async_reset("rst_s3");
    car_r = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) car_r = ~car_r;
      if ($urandom_range(0, 399) == 0) async_reset("rst_rand");
      else tick(car_r);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
